layer_compositor: RTL and testbench

LAYER_COMPOSITOR -- requirements
Module: layer_compositor

---
 rtl/compositor_pkg.sv | 25 ++
 rtl/layer_priority_enc.sv | 34 +++
 rtl/layer_compositor.sv | 131 +++++++++++++
 tb/tb_layer_compositor.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/compositor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : compositor_pkg
//  Description : Shared types, constants and colour helper for the sprite
//                layer compositor.
//  Revision    : 1.0 - initial release
// ============================================================================
package compositor_pkg;

  typedef logic [7:0] rgb332_t;

  // Colour key that marks a layer pixel as "nothing drawn here"
  localparam rgb332_t TRANSPARENT_DEFAULT = 8'hFF;

  // Widest layer stack the compositor supports
  localparam int MAX_LAYERS = 16;

  // RGB332 -> 24-bit {R,G,B}; the LSB of each field is replicated into the
  // low bits so that full-scale codes map to 8'hFF.
  function automatic logic [23:0] expand_rgb332(input rgb332_t c);
    return {c[7:5], {5{c[5]}}, c[4:2], {5{c[2]}}, c[1:0], {6{c[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/layer_priority_enc.sv
`default_nettype none
// ============================================================================
//  Module      : layer_priority_enc
//  Description : Finds the lowest-index set bit of a layer hit vector and
//                flags whether zero, one or several layers hit.
//                index = NUM_LAYERS when no layer hits.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_priority_enc #(
  parameter  int NUM_LAYERS = 8,
  localparam int IDX_W      = $clog2(NUM_LAYERS + 1)
) (
  input  logic [NUM_LAYERS-1:0] hit,
  output logic [IDX_W-1:0]      index,
  output logic                  any_hit,
  output logic                  multi_hit
);

  // Scan from the top down so the lowest index overwrites last and wins
  always_comb begin
    index = IDX_W'(NUM_LAYERS);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (hit[i]) index = IDX_W'(i);
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set
  always_comb begin
    any_hit   = |hit;
    multi_hit = |(hit & (hit - NUM_LAYERS'(1)));
  end

endmodule
`default_nettype wire

// File: rtl/layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : layer_compositor
//  Description : Two-stage priority compositor for NUM_LAYERS RGB332 sprite
//                layers over a background, with per-pixel collision pulse
//                and per-frame collision flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_compositor
  import compositor_pkg::*;
#(
  parameter  int      NUM_LAYERS  = 8,
  parameter  rgb332_t TRANSPARENT = TRANSPARENT_DEFAULT,
  localparam int      TOP_W       = $clog2(NUM_LAYERS + 1)
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic [NUM_LAYERS-1:0]   drawReq,
  input  logic [NUM_LAYERS*8-1:0] layerRGB,
  input  logic [NUM_LAYERS-1:0]   layerEnable,
  input  logic [7:0]              backGroundRGB,
  input  logic                    startOfFrame,
  output logic [7:0]              redOut,
  output logic [7:0]              greenOut,
  output logic [7:0]              blueOut,
  output logic [TOP_W-1:0]        topLayer,
  output logic                    collisionPulse,
  output logic [NUM_LAYERS-1:0]   collisionFlags
);

  if (NUM_LAYERS < 2 || NUM_LAYERS > MAX_LAYERS) begin : g_bad_num_layers
    $error("layer_compositor: NUM_LAYERS must be in 2..16");
  end

  // Valid hit: requested, enabled and not the colour key
  logic [NUM_LAYERS-1:0] hit_vec;
  for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_hit
    assign hit_vec[gi] = drawReq[gi] & layerEnable[gi] &
                         (layerRGB[8*gi +: 8] != TRANSPARENT);
  end

  // ---------------- stage 1 ----------------
  logic [NUM_LAYERS-1:0]   hit_q, hit_d;
  logic [NUM_LAYERS*8-1:0] rgb_q, rgb_d;
  rgb332_t                 bg_q,  bg_d;
  logic                    sof_q, sof_d;

  // Stage-1 next state: capture the raw pixel inputs and the hit vector
  always_comb begin
    hit_d = hit_vec;
    rgb_d = layerRGB;
    bg_d  = backGroundRGB;
    sof_d = startOfFrame;
  end

  // Stage-1 register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hit_q <= '0;
      rgb_q <= '0;
      bg_q  <= '0;
      sof_q <= 1'b0;
    end else begin
      hit_q <= hit_d;
      rgb_q <= rgb_d;
      bg_q  <= bg_d;
      sof_q <= sof_d;
    end
  end

  // ---------------- stage 2 ----------------
  logic [TOP_W-1:0] enc_index;
  logic             enc_any;
  logic             enc_multi;

  layer_priority_enc #(
    .NUM_LAYERS (NUM_LAYERS)
  ) u_priority_enc (
    .hit       (hit_q),
    .index     (enc_index),
    .any_hit   (enc_any),
    .multi_hit (enc_multi)
  );

  rgb332_t               color_q, color_d;
  logic [TOP_W-1:0]      top_q,   top_d;
  logic                  coll_q,  coll_d;
  logic [NUM_LAYERS-1:0] acc_q,   acc_d;
  logic [NUM_LAYERS-1:0] flags_q, flags_d;
  logic [NUM_LAYERS-1:0] contrib;

  // Stage-2 next state: winner colour, collision pulse and frame bookkeeping
  always_comb begin
    color_d = bg_q;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (enc_any && enc_index == TOP_W'(i)) color_d = rgb_q[8*i +: 8];
    end
    top_d   = enc_index;
    coll_d  = enc_multi;
    // Only collision pixels feed the accumulator; a lone hit adds nothing
    contrib = enc_multi ? hit_q : '0;
    // At a frame boundary the finished frame is published and the new one
    // starts with just the boundary pixel's own collision, if any
    acc_d   = sof_q ? contrib : (acc_q | contrib);
    flags_d = sof_q ? acc_q : flags_q;
  end

  // Stage-2 register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      color_q <= '0;
      top_q   <= '0;
      coll_q  <= 1'b0;
      acc_q   <= '0;
      flags_q <= '0;
    end else begin
      color_q <= color_d;
      top_q   <= top_d;
      coll_q  <= coll_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
    end
  end

  assign {redOut, greenOut, blueOut} = expand_rgb332(color_q);
  assign topLayer       = top_q;
  assign collisionPulse = coll_q;
  assign collisionFlags = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer_compositor
//  Description : Directed self-checking bench for layer_compositor
//                (NUM_LAYERS = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_compositor;

  localparam int NL = 8;

  logic          clk = 1'b0;
  logic          resetN;
  logic [NL-1:0] draw;
  logic [NL*8-1:0] lrgb;
  logic [NL-1:0] en;
  logic [7:0]    bg;
  logic          sof;
  logic [7:0]    red, green, blue;
  logic [3:0]    top;
  logic          pulse;
  logic [NL-1:0] flags;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  layer_compositor #(
    .NUM_LAYERS  (NL),
    .TRANSPARENT (8'hFF)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .drawReq        (draw),
    .layerRGB       (lrgb),
    .layerEnable    (en),
    .backGroundRGB  (bg),
    .startOfFrame   (sof),
    .redOut         (red),
    .greenOut       (green),
    .blueOut        (blue),
    .topLayer       (top),
    .collisionPulse (pulse),
    .collisionFlags (flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    draw = '0;
    lrgb = {NL{8'hFF}};
    en   = '1;
    bg   = 8'h00;
    sof  = 1'b0;
  endtask

  initial begin
    resetN = 1'b0;
    idle();
    #2;
    check("rst_red",   {24'd0, red},   32'h00);
    check("rst_green", {24'd0, green}, 32'h00);
    check("rst_blue",  {24'd0, blue},  32'h00);
    check("rst_top",   {28'd0, top},   32'h0);
    check("rst_pulse", {31'd0, pulse}, 32'h0);
    check("rst_flags", {24'd0, flags}, 32'h00);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    tick();

    // Single layer: layer 3 pure red
    draw = 8'h08; lrgb[31:24] = 8'hE0;
    tick(); idle(); tick();
    check("single_red",   {24'd0, red},   32'hFF);
    check("single_green", {24'd0, green}, 32'h00);
    check("single_blue",  {24'd0, blue},  32'h00);
    check("single_top",   {28'd0, top},   32'd3);
    check("single_pulse", {31'd0, pulse}, 32'h0);
    tick();
    check("single_next_top", {28'd0, top}, 32'd8);

    // Priority + mask: layer 1 disabled, layer 2 blue wins alone
    draw = 8'h06; lrgb[15:8] = 8'h1C; lrgb[23:16] = 8'h03; en = 8'hFD;
    tick(); idle(); tick();
    check("mask_top",   {28'd0, top},   32'd2);
    check("mask_blue",  {24'd0, blue},  32'hFF);
    check("mask_red",   {24'd0, red},   32'h00);
    check("mask_pulse", {31'd0, pulse}, 32'h0);

    // Transparency: background 8'h49 = 010_010_01
    // red {010,00000}=40, green {010,00000}=40, blue {01,111111}=7F
    draw = 8'h01; lrgb[7:0] = 8'hFF; bg = 8'h49;
    tick(); idle(); tick();
    check("transp_top",   {28'd0, top},   32'd8);
    check("transp_red",   {24'd0, red},   32'h40);
    check("transp_green", {24'd0, green}, 32'h40);
    check("transp_blue",  {24'd0, blue},  32'h7F);

    // Collision frame: open a frame, overlap layers 0 and 5 once
    sof = 1'b1;
    tick(); idle(); tick();
    check("sof0_flags", {24'd0, flags}, 32'h00);
    tick();
    draw = 8'h21; lrgb[7:0] = 8'h80; lrgb[47:40] = 8'h1C;
    tick(); idle(); tick();
    check("coll_pulse", {31'd0, pulse}, 32'h1);
    check("coll_top",   {28'd0, top},   32'd0);
    check("coll_red",   {24'd0, red},   32'h80);
    tick();
    check("coll_pulse_off", {31'd0, pulse}, 32'h0);
    check("coll_flags_hold", {24'd0, flags}, 32'h00);
    tick();
    sof = 1'b1;
    tick(); idle(); tick();
    check("frame_flags", {24'd0, flags}, 32'h21);
    tick(); tick();
    check("frame_flags_hold", {24'd0, flags}, 32'h21);
    sof = 1'b1;
    tick(); idle(); tick();
    check("empty_flags", {24'd0, flags}, 32'h00);

    // SOF coincident with a collision
    draw = 8'h0A; lrgb[15:8] = 8'h10; lrgb[31:24] = 8'h20;
    tick(); idle(); tick();
    check("c13_pulse", {31'd0, pulse}, 32'h1);
    check("c13_top",   {28'd0, top},   32'd1);
    sof = 1'b1; draw = 8'h14; lrgb[23:16] = 8'h03; lrgb[39:32] = 8'hE0;
    tick(); idle(); tick();
    check("sofc_flags", {24'd0, flags}, 32'h0A);
    check("sofc_pulse", {31'd0, pulse}, 32'h1);
    check("sofc_top",   {28'd0, top},   32'd2);
    tick();
    sof = 1'b1;
    tick(); idle(); tick();
    check("sofc_next_flags", {24'd0, flags}, 32'h14);

    // Reset mid-stream: a collision sits in the accumulator, a hit in flight
    draw = 8'h03; lrgb[7:0] = 8'h80; lrgb[15:8] = 8'h1C;
    tick(); idle(); tick();
    draw = 8'h08; lrgb[31:24] = 8'hE0;
    tick();
    #2 resetN = 1'b0;
    #1;
    check("arst_red",   {24'd0, red},   32'h00);
    check("arst_top",   {28'd0, top},   32'd0);
    check("arst_pulse", {31'd0, pulse}, 32'h0);
    check("arst_flags", {24'd0, flags}, 32'h00);
    idle();
    @(negedge clk);
    resetN = 1'b1;
    tick();
    draw = 8'h81; lrgb[7:0] = 8'h80; lrgb[63:56] = 8'h03;
    tick(); idle(); tick();
    check("post_pulse", {31'd0, pulse}, 32'h1);
    check("post_top",   {28'd0, top},   32'd0);
    check("post_red",   {24'd0, red},   32'h80);
    sof = 1'b1;
    tick(); idle(); tick();
    check("post_flags", {24'd0, flags}, 32'h81);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
